mem_port_arbiter: RTL and testbench

//  N-port arbiter sharing one single-ported memory bus between processor requesters (imem, dmem, future DMA/debug).

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : N-port arbiter sharing one single-ported memory bus.
// Optional macro: MEM_ARB_FIXED_PRIORITY_EN (lowest index wins, no rotation).
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        ien_mem_re,
  input  logic [NUM_PORTS-1:0]        ien_mem_wr,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS*DATA_W-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]        port_ready,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        oen_mem_re,
  output logic                        oen_mem_wr,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]              grant_q, grant_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          oen_re_q, oen_re_d;
  logic                          oen_wr_q, oen_wr_d;
  logic [NUM_PORTS*DATA_W-1:0]   port_rdata_q, port_rdata_d;
  logic [NUM_PORTS-1:0]          port_ready_q, port_ready_d;

  logic [NUM_PORTS-1:0]          req;
  logic [IDX_W-1:0]              winner;
  logic [IDX_W-1:0]              next_ptr;

  assign req = ien_mem_re | ien_mem_wr;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end

  assign next_ptr = '0;
`else
  // Scan upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    int  cand;
    logic found;
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand]) begin
        winner = IDX_W'(cand);
        found  = 1'b1;
      end
    end
  end

  assign next_ptr = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    oen_re_d     = oen_re_q;
    oen_wr_d     = oen_wr_q;
    port_rdata_d = port_rdata_q;
    port_ready_d = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = BUSY;
          grant_d  = winner;
          addr_d   = port_addr[winner*ADDR_W +: ADDR_W];
          wdata_d  = port_wdata[winner*DATA_W +: DATA_W];
          // Write takes precedence when a port raises both enables.
          oen_wr_d = ien_mem_wr[winner];
          oen_re_d = ~ien_mem_wr[winner];
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d               = DONE;
          oen_re_d              = 1'b0;
          oen_wr_d              = 1'b0;
          port_ready_d[grant_q] = 1'b1;
          if (oen_re_q) begin
            port_rdata_d[grant_q*DATA_W +: DATA_W] = mem_rdata;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end
      default: begin
        state_d  = IDLE;
        oen_re_d = 1'b0;
        oen_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oen_re_q     <= 1'b0;
      oen_wr_q     <= 1'b0;
      port_rdata_q <= '0;
      port_ready_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      oen_re_q     <= oen_re_d;
      oen_wr_q     <= oen_wr_d;
      port_rdata_q <= port_rdata_d;
      port_ready_q <= port_ready_d;
    end
  end

  assign port_rdata = port_rdata_q;
  assign port_ready = port_ready_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign oen_mem_re = oen_re_q;
  assign oen_mem_wr = oen_wr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed + randomized checks against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    ien_mem_re = '0;
  logic [N-1:0]    ien_mem_wr = '0;
  logic [N*AW-1:0] port_addr  = '0;
  logic [N*DW-1:0] port_wdata = '0;
  logic [N*DW-1:0] port_rdata;
  logic [N-1:0]    port_ready;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            oen_mem_re;
  logic            oen_mem_wr;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: rotation pointer and last read value per port.
  int          rr = 0;
  logic [DW-1:0] exp_rd [N];

  mem_port_arbiter #(
    .NUM_PORTS(N), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .ien_mem_re(ien_mem_re), .ien_mem_wr(ien_mem_wr),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .port_ready(port_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .oen_mem_re(oen_mem_re), .oen_mem_wr(oen_mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rdata(input string tag);
    for (int p = 0; p < N; p++) check(tag, port_rdata[p*DW +: DW], exp_rd[p]);
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Called at #1 after an edge with the arbiter idle; returns at #1 after an edge, idle again.
  task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] w,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                         input logic [DW-1:0] rd, input int delay, input bit drop);
    int           win;
    bit           is_wr;
    logic [N-1:0] onehot;
    ien_mem_re = r;
    ien_mem_wr = w;
    port_addr  = a;
    port_wdata = d;
    win = pick(r | w, rr);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (win < 0) begin
      check("idle_noreq_en", {oen_mem_wr, oen_mem_re}, 2'b00);
      check("idle_noreq_ready", port_ready, '0);
      return;
    end
    is_wr = w[win];
    check("busy_en", {oen_mem_wr, oen_mem_re}, is_wr ? 2'b10 : 2'b01);
    check("busy_addr", mem_addr, a[win*AW +: AW]);
    check("busy_wdata", mem_wdata, d[win*DW +: DW]);
    check("busy_ready", port_ready, '0);
    if (drop) begin
      ien_mem_re = '0;
      ien_mem_wr = '0;
    end
    for (int c = 0; c < delay; c++) begin
      @(posedge clk); #1;
      check("hold_en", {oen_mem_wr, oen_mem_re}, is_wr ? 2'b10 : 2'b01);
      check("hold_addr", mem_addr, a[win*AW +: AW]);
      check("hold_ready", port_ready, '0);
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(posedge clk); #1;
    if (!is_wr) exp_rd[win] = rd;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    rr = 0;
`else
    rr = (win + 1) % N;
`endif
    onehot = '0;
    onehot[win] = 1'b1;
    check("done_ready", port_ready, onehot);
    check("done_en", {oen_mem_wr, oen_mem_re}, 2'b00);
    check_rdata("done_rdata");
    // Requests and mem_ready during the completion cycle must be ignored.
    mem_ready  = 1'($urandom_range(1));
    mem_rdata  = $urandom;
    ien_mem_re = N'($urandom);
    ien_mem_wr = N'($urandom);
    @(posedge clk); #1;
    check("post_ready", port_ready, '0);
    check("post_en", {oen_mem_wr, oen_mem_re}, 2'b00);
  endtask

  function automatic logic [N*AW-1:0] rand_addr();
    logic [N*AW-1:0] v;
    for (int p = 0; p < N; p++) v[p*AW +: AW] = $urandom;
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] v;
    for (int p = 0; p < N; p++) v[p*DW +: DW] = $urandom;
    return v;
  endfunction

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    int              pre_win;
    for (int p = 0; p < N; p++) exp_rd[p] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_en", {oen_mem_wr, oen_mem_re}, 2'b00);
    check("reset_ready", port_ready, '0);
    check("reset_addr", mem_addr, '0);
    check("reset_wdata", mem_wdata, '0);
    check_rdata("reset_rdata");

    // mem_ready asserted with nobody requesting
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_ready", port_ready, '0);
      check("stray_en", {oen_mem_wr, oen_mem_re}, 2'b00);
    end
    mem_ready = 1'b0;

    // Single read on port 1, two busy cycles
    a = rand_addr();
    a[1*AW +: AW] = 32'h40;
    run_txn(3'b010, 3'b000, a, rand_data(), 32'hDEADBEEF, 1, 1'b0);

    // re+wr on port 0 behaves as a write
    a = rand_addr();
    d = rand_data();
    a[0 +: AW] = 32'h10;
    d[0 +: DW] = 32'h5;
    run_txn(3'b001, 3'b001, a, d, $urandom, 0, 1'b0);

    // Ports 0 and 1 requesting back-to-back with single-cycle memory
    repeat (6) run_txn(3'b011, 3'b000, rand_addr(), rand_data(), $urandom, 0, 1'b0);

    // Reset in the middle of a read
    run_txn(3'b001, 3'b000, rand_addr(), rand_data(), $urandom, 0, 1'b0);
    a = rand_addr();
    port_addr  = a;
    ien_mem_re = 3'b011;
    ien_mem_wr = 3'b000;
    pre_win = pick(3'b011, rr);
    @(posedge clk); #1;
    check("rst_pre_en", {oen_mem_wr, oen_mem_re}, 2'b01);
    check("rst_pre_addr", mem_addr, a[pre_win*AW +: AW]);
    #2 rst = 1'b1;
    #1;
    check("rst_async_en", {oen_mem_wr, oen_mem_re}, 2'b00);
    check("rst_async_ready", port_ready, '0);
    for (int p = 0; p < N; p++) exp_rd[p] = '0;
    rr = 0;
    check_rdata("rst_async_rdata");
    ien_mem_re = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_after_ready", port_ready, '0);
    run_txn(3'b011, 3'b000, rand_addr(), rand_data(), $urandom, 1, 1'b0);

    // Randomized traffic
    repeat (60) begin
      run_txn(N'($urandom), N'($urandom & $urandom), rand_addr(), rand_data(),
              $urandom, $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
